// File: rtl/pipeline_ctrl.sv
// Pipeline control sequencer: per-register enable/clear, PC write enable, HLT drain
// and saturating stall/flush performance counters for a 4-register CPU pipeline.
module pipeline_ctrl #(
  parameter int CNT_W = 16,
  parameter int DRAIN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             halt_id,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [1:0] drain_cnt;
  logic       go_drain;
  logic       squash;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Control decode: combinational from state and current hazard inputs
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    go_drain  = 1'b0;
    squash    = 1'b0;
    if (rst) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
      memwb_clr = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (dcache_stall) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_clr = 1'b1;
          end else if (load_use) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
          end else if (halt_id) begin
            pc_en    = 1'b0;
            ifid_clr = 1'b1;
            go_drain = 1'b1;
          end else if (branch_taken) begin
            ifid_clr = 1'b1;
            squash   = 1'b1;
          end else if (icache_stall) begin
            pc_en    = 1'b0;
            ifid_clr = 1'b1;
          end
        end
        ST_DRAIN: begin
          pc_en    = 1'b0;
          ifid_clr = 1'b1;
          if (dcache_stall) begin
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_clr = 1'b1;
          end
        end
        default: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
      endcase
    end
  end

  // State, drain countdown, halted flag and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= 2'd0;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == ST_RUN && !pc_en)
        stall_cnt <= sat_inc(stall_cnt);
      if (squash)
        flush_cnt <= sat_inc(flush_cnt);
      case (state)
        ST_RUN: begin
          if (go_drain) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        ST_DRAIN: begin
          // A D-cache freeze holds the HLT in place, so the countdown waits too
          if (!dcache_stall) begin
            if (drain_cnt == 2'd0) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 2'd1;
            end
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: expected control vectors are queued at
// drive time and popped when the combinational outputs are sampled.
module tb_pipeline_ctrl;

  localparam int CNT_W = 16;

  // ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr, memwb_clr}
  localparam logic [8:0] V_RUN = 9'b1_1111_0000;
  localparam logic [8:0] V_RST = 9'b0_0000_1111;
  localparam logic [8:0] V_DC  = 9'b0_0001_0001;
  localparam logic [8:0] V_LU  = 9'b0_0111_0100;
  localparam logic [8:0] V_FL  = 9'b0_1111_1000;
  localparam logic [8:0] V_BR  = 9'b1_1111_1000;
  localparam logic [8:0] V_DDC = 9'b0_0001_1001;
  localparam logic [8:0] V_HLT = 9'b0_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_use = 1'b0, branch_taken = 1'b0, halt_id = 1'b0;
  logic icache_stall = 1'b0, dcache_stall = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] ctrl;

  logic [8:0] sb[$];
  logic [8:0] e;
  int n_vec = 0;
  int n_err = 0;

  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_clr, idex_clr, exmem_clr, memwb_clr};

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN(3)) dut (
    .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
    .halt_id(halt_id), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .memwb_clr(memwb_clr), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Drive inputs just after a falling edge, queue the expected control vector, let it settle
  task automatic apply(input logic r, input logic lu, input logic bt, input logic hl,
                       input logic ic, input logic dc, input logic [8:0] exp_v);
    rst = r; load_use = lu; branch_taken = bt; halt_id = hl;
    icache_stall = ic; dcache_stall = dc;
    sb.push_back(exp_v);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_use = 1'b0; branch_taken = 1'b0; halt_id = 1'b0;
    icache_stall = 1'b0; dcache_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 0, 0, 0, V_RST);
      e = sb.pop_front(); n_vec++;
      if (ctrl !== e) begin n_err++; $display("FAIL reset_ctrl[%0d] got %b want %b", i, ctrl, e); end
      @(negedge clk);
    end
    apply(0, 0, 0, 0, 0, 0, V_RUN);
    e = sb.pop_front(); n_vec++;
    if (ctrl !== e) begin n_err++; $display("FAIL reset_run_ctrl got %b want %b", ctrl, e); end
    n_vec++;
    if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
    n_vec++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    do_reset();
    apply(0, 1, 1, 0, 0, 0, V_LU);
    e = sb.pop_front(); n_vec++;
    if (ctrl !== e) begin n_err++; $display("FAIL load_use_ctrl got %b want %b", ctrl, e); end
    @(negedge clk);
    n_vec++;
    if (stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL load_use_cnt got stall=%0d flush=%0d want 1/0", stall_cnt, flush_cnt);
    end
    apply(0, 0, 0, 0, 0, 0, V_RUN);
    e = sb.pop_front(); n_vec++;
    if (ctrl !== e) begin n_err++; $display("FAIL load_use_after got %b want %b", ctrl, e); end
    @(negedge clk);
  endtask

  task automatic test_branch_icache();
    do_reset();
    apply(0, 0, 1, 0, 1, 0, V_BR);
    e = sb.pop_front(); n_vec++;
    if (ctrl !== e) begin n_err++; $display("FAIL branch_ctrl got %b want %b", ctrl, e); end
    @(negedge clk);
    n_vec++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd1) begin
      n_err++; $display("FAIL branch_cnt got stall=%0d flush=%0d want 0/1", stall_cnt, flush_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 1, 0, V_FL);
      e = sb.pop_front(); n_vec++;
      if (ctrl !== e) begin n_err++; $display("FAIL icache_ctrl[%0d] got %b want %b", i, ctrl, e); end
      @(negedge clk);
    end
    n_vec++;
    if (stall_cnt !== 16'd4 || flush_cnt !== 16'd1) begin
      n_err++; $display("FAIL icache_cnt got stall=%0d flush=%0d want 4/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_dcache();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(0, i[0], i[1], 0, 1, 1, V_DC);
      e = sb.pop_front(); n_vec++;
      if (ctrl !== e) begin n_err++; $display("FAIL dcache_ctrl[%0d] got %b want %b", i, ctrl, e); end
      @(negedge clk);
    end
    n_vec++;
    if (stall_cnt !== 16'd5 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL dcache_cnt got stall=%0d flush=%0d want 5/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_priority();
    logic [5:0] stim [4];
    logic [8:0] expv [4];
    do_reset();
    // {lu, bt, hl, ic, dc} with expected vector
    stim[0] = 6'b011110; expv[0] = V_LU;
    stim[1] = 6'b001110; expv[1] = V_RUN;
    stim[2] = 6'b000110; expv[2] = V_RUN;
    stim[3] = 6'b000010; expv[3] = V_RUN;
    // lu beats halt; bt wins over ic; bare ic stalls; then idle
    expv[1] = V_BR; stim[1] = 6'b001010;
    expv[2] = V_FL; stim[2] = 6'b000010;
    expv[3] = V_RUN; stim[3] = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      apply(0, stim[i][4], stim[i][3], stim[i][2], stim[i][1], stim[i][0], expv[i]);
      e = sb.pop_front(); n_vec++;
      if (ctrl !== e) begin n_err++; $display("FAIL priority_ctrl[%0d] got %b want %b", i, ctrl, e); end
      @(negedge clk);
    end
    n_vec++;
    if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
      n_err++; $display("FAIL priority_cnt got stall=%0d flush=%0d want 2/1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_halt_drain();
    logic [8:0] expv [5];
    logic       dcv  [5];
    do_reset();
    expv[0] = V_FL;  dcv[0] = 1'b0;
    expv[1] = V_FL;  dcv[1] = 1'b0;
    expv[2] = V_DDC; dcv[2] = 1'b1;
    expv[3] = V_FL;  dcv[3] = 1'b0;
    expv[4] = V_FL;  dcv[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, i == 3, i == 0, i == 1, dcv[i], expv[i]);
      e = sb.pop_front(); n_vec++;
      if (ctrl !== e) begin n_err++; $display("FAIL drain_ctrl[%0d] got %b want %b", i, ctrl, e); end
      @(negedge clk);
      n_vec++;
      if (halted !== (i == 4)) begin
        n_err++; $display("FAIL drain_halted[%0d] got %b want %b", i, halted, (i == 4));
      end
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, i != 1, i != 2, i == 2, i == 1, i == 2, V_HLT);
      e = sb.pop_front(); n_vec++;
      if (ctrl !== e) begin n_err++; $display("FAIL halted_ctrl[%0d] got %b want %b", i, ctrl, e); end
      @(negedge clk);
    end
    n_vec++;
    if (halted !== 1'b1 || stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL halted_frozen got halted=%b stall=%0d flush=%0d want 1/1/0", halted, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_rst_in_drain();
    do_reset();
    apply(0, 0, 0, 1, 0, 0, V_FL);
    e = sb.pop_front(); n_vec++;
    if (ctrl !== e) begin n_err++; $display("FAIL rstdrain_halt got %b want %b", ctrl, e); end
    @(negedge clk);
    apply(0, 0, 0, 0, 0, 0, V_FL);
    e = sb.pop_front(); n_vec++;
    if (ctrl !== e) begin n_err++; $display("FAIL rstdrain_d1 got %b want %b", ctrl, e); end
    @(negedge clk);
    apply(1, 0, 0, 0, 0, 0, V_RST);
    e = sb.pop_front(); n_vec++;
    if (ctrl !== e) begin n_err++; $display("FAIL rstdrain_rst got %b want %b", ctrl, e); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 0, 0, 0, V_RUN);
      e = sb.pop_front(); n_vec++;
      if (ctrl !== e || halted !== 1'b0) begin
        n_err++; $display("FAIL rstdrain_run[%0d] got %b/%b want %b/0", i, ctrl, halted, e);
      end
      @(negedge clk);
    end
    n_vec++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL rstdrain_cnt got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    apply(0, 0, 0, 0, 1, 0, V_FL);
    e = sb.pop_front(); n_vec++;
    if (ctrl !== e) begin n_err++; $display("FAIL sat_ctrl got %b want %b", ctrl, e); end
    for (int i = 0; i < 65534; i++) @(negedge clk);
    n_vec++;
    if (stall_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre got %h want fffe", stall_cnt); end
    for (int i = 0; i < 6; i++) @(negedge clk);
    n_vec++;
    if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want ffff", stall_cnt); end
    icache_stall = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_icache();
    test_dcache();
    test_priority();
    test_halt_drain();
    test_rst_in_drain();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
